// File: rtl/bcd_time_sequencer.sv
// Six-field packed BCD timestamp to binary, one field per cycle through a single
// shared two-digit converter; results publish atomically only when all fields pass.
module bcd2_conv (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       digits_ok
);
  logic [3:0] tens, units;

  assign tens      = bcd[7:4];
  assign units     = bcd[3:0];
  // tens*10 = tens*8 + tens*2; wraps only for non-decimal digits, which fail anyway
  assign bin       = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
  assign digits_ok = (tens <= 4'd9) && (units <= 4'd9);
endmodule

module bcd_time_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_field,
  output logic [5:0]  sec_bin,
  output logic [5:0]  min_bin,
  output logic [4:0]  hour_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic [6:0]  year_bin
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state;
  logic [47:0]      shadow;
  logic [2:0]       idx;
  logic [5:0][6:0]  staging;

  logic [7:0]       cur_byte;
  logic [6:0]       cur_bin, lo, hi;
  logic             cur_digits_ok, field_ok;

  // field select and its legal range; the converter only ever sees the shadow copy
  always_comb begin
    cur_byte = 8'h00;
    lo       = 7'd0;
    hi       = 7'd0;
    case (idx)
      3'd0: begin cur_byte = shadow[7:0];   lo = 7'd0; hi = 7'd59; end
      3'd1: begin cur_byte = shadow[15:8];  lo = 7'd0; hi = 7'd59; end
      3'd2: begin cur_byte = shadow[23:16]; lo = 7'd0; hi = 7'd23; end
      3'd3: begin cur_byte = shadow[31:24]; lo = 7'd1; hi = 7'd31; end
      3'd4: begin cur_byte = shadow[39:32]; lo = 7'd1; hi = 7'd12; end
      3'd5: begin cur_byte = shadow[47:40]; lo = 7'd0; hi = 7'd99; end
      default: ;
    endcase
  end

  bcd2_conv u_conv (
    .bcd       (cur_byte),
    .bin       (cur_bin),
    .digits_ok (cur_digits_ok)
  );

  assign field_ok = cur_digits_ok && (cur_bin >= lo) && (cur_bin <= hi);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      idx       <= '0;
      staging   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_field <= 3'd7;
      sec_bin   <= '0;
      min_bin   <= '0;
      hour_bin  <= '0;
      day_bin   <= '0;
      month_bin <= '0;
      year_bin  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shadow    <= bcd_in;
          idx       <= 3'd0;
          err       <= 1'b0;
          err_field <= 3'd7;
          busy      <= 1'b1;
          state     <= CONV;
        end
        CONV: if (!field_ok) begin
          err       <= 1'b1;
          err_field <= idx;
          done      <= 1'b1;
          state     <= DONE;
        end else begin
          for (int i = 0; i < 6; i++)
            if (idx == 3'(i)) staging[i] <= cur_bin;
          if (idx == 3'd5) begin
            // year comes straight from the converter: staging[5] lands on this same edge
            sec_bin   <= staging[0][5:0];
            min_bin   <= staging[1][5:0];
            hour_bin  <= staging[2][4:0];
            day_bin   <= staging[3][4:0];
            month_bin <= staging[4][3:0];
            year_bin  <= cur_bin;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_time_sequencer.sv
// Randomized self-checking bench for bcd_time_sequencer against a field-rule model.
module tb_bcd_time_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [47:0] bcd_in = '0;
  logic        busy, done, err;
  logic [2:0]  err_field;
  logic [5:0]  sec_bin, min_bin;
  logic [4:0]  hour_bin, day_bin;
  logic [3:0]  month_bin;
  logic [6:0]  year_bin;

  int          checks = 0, errors = 0;
  logic [32:0] exp_bins = '0;

  int          r_lat, r_ndone;
  logic        r_err, r_busy_after;
  logic [2:0]  r_ef;
  logic [32:0] r_bins;

  always #5 clk = ~clk;

  bcd_time_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .err_field(err_field),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin)
  );

  function automatic int fld(input logic [47:0] d, input int i);
    logic [7:0] b;
    b = d[i*8 +: 8];
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // index of first failing field, 7 when all fields are legal
  function automatic int model_fail(input logic [47:0] d);
    int lo[6] = '{0, 0, 0, 1, 1, 0};
    int hi[6] = '{59, 59, 23, 31, 12, 99};
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = d[i*8 +: 8];
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9 || fld(d, i) < lo[i] || fld(d, i) > hi[i])
        return i;
    end
    return 7;
  endfunction

  function automatic logic [32:0] model_bins(input logic [47:0] d);
    return {7'(fld(d, 5)), 4'(fld(d, 4)), 5'(fld(d, 3)), 5'(fld(d, 2)),
            6'(fld(d, 1)), 6'(fld(d, 0))};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [47:0] rand_valid();
    return {to_bcd($urandom_range(99)), to_bcd($urandom_range(12, 1)),
            to_bcd($urandom_range(31, 1)), to_bcd($urandom_range(23)),
            to_bcd($urandom_range(59)), to_bcd($urandom_range(59))};
  endfunction

  function automatic logic [32:0] dut_bins();
    return {year_bin, month_bin, day_bin, hour_bin, min_bin, sec_bin};
  endfunction

  // Accepts d, then watches 20 edges; r_lat is done's cycle counted from the accept edge.
  // With disturb, a second start plus new data arrive at accept+3.
  task automatic run_seq(input logic [47:0] d, input bit disturb);
    int w;
    w = 0;
    @(negedge clk);
    while (busy !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      checks++; errors++;
      $display("FAIL idle_wait busy=%b required 0 within 50 cycles", busy);
    end
    bcd_in = d;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = {16'($urandom), $urandom};
    r_lat = 0; r_ndone = 0; r_err = 1'bx; r_ef = 3'bx; r_bins = 'x; r_busy_after = 1'bx;
    for (int e = 1; e <= 20; e++) begin
      if (disturb && e == 3) begin start = 1'b1; bcd_in = ~d; end
      @(posedge clk); #1;
      if (disturb && e == 3) start = 1'b0;
      if (r_ndone >= 1 && e == r_lat) r_busy_after = busy;
      if (done === 1'b1) begin
        r_ndone++;
        if (r_ndone == 1) begin
          r_lat = e + 1; r_err = err; r_ef = err_field; r_bins = dut_bins();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b1;
    bcd_in = 48'h99_12_31_23_59_58;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b need 0", done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b need 0", err); end
    if (err_field !== 3'd7) begin errors++; $display("FAIL reset_err_field got %0d need 7", err_field); end
    if (dut_bins() !== '0)  begin errors++; $display("FAIL reset_bins got %h need 0", dut_bins()); end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy=%b need 0", busy); end
  endtask

  task automatic test_valid_max();
    logic [47:0] d;
    d = 48'h99_12_31_23_59_58;
    run_seq(d, 1'b0);
    exp_bins = {7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd58};
    checks += 6;
    if (r_ndone !== 1)          begin errors++; $display("FAIL max_done_count got %0d need 1", r_ndone); end
    if (r_lat !== 7)            begin errors++; $display("FAIL max_latency got %0d need 7", r_lat); end
    if (r_err !== 1'b0)         begin errors++; $display("FAIL max_err got %b need 0", r_err); end
    if (r_ef !== 3'd7)          begin errors++; $display("FAIL max_err_field got %0d need 7", r_ef); end
    if (r_bins !== exp_bins)    begin errors++; $display("FAIL max_bins got %h need %h", r_bins, exp_bins); end
    if (r_busy_after !== 1'b0)  begin errors++; $display("FAIL max_busy_after got %b need 0", r_busy_after); end
  endtask

  task automatic test_bad_digit();
    run_seq(48'h99_12_31_2A_59_58, 1'b0);
    checks += 5;
    if (r_ndone !== 1)       begin errors++; $display("FAIL digit_done_count got %0d need 1", r_ndone); end
    if (r_lat !== 4)         begin errors++; $display("FAIL digit_latency got %0d need 4", r_lat); end
    if (r_err !== 1'b1)      begin errors++; $display("FAIL digit_err got %b need 1", r_err); end
    if (r_ef !== 3'd2)       begin errors++; $display("FAIL digit_err_field got %0d need 2", r_ef); end
    if (r_bins !== exp_bins) begin errors++; $display("FAIL digit_bins got %h need %h", r_bins, exp_bins); end
  endtask

  task automatic test_range_errors();
    logic [47:0] tbl [3] = '{48'h99_13_31_23_59_58, 48'h99_12_00_23_59_58, 48'h99_12_31_23_59_60};
    int          fld_exp [3] = '{4, 3, 0};
    int          lat_exp [3] = '{6, 5, 2};
    for (int i = 0; i < 3; i++) begin
      run_seq(tbl[i], 1'b0);
      checks += 4;
      if (r_lat !== lat_exp[i])       begin errors++; $display("FAIL range%0d_latency got %0d need %0d", i, r_lat, lat_exp[i]); end
      if (r_err !== 1'b1)             begin errors++; $display("FAIL range%0d_err got %b need 1", i, r_err); end
      if (r_ef !== 3'(fld_exp[i]))    begin errors++; $display("FAIL range%0d_err_field got %0d need %0d", i, r_ef, fld_exp[i]); end
      if (r_bins !== exp_bins)        begin errors++; $display("FAIL range%0d_bins got %h need %h", i, r_bins, exp_bins); end
    end
    @(negedge clk);
    checks += 2;
    if (err !== 1'b1)       begin errors++; $display("FAIL err_hold got %b need 1", err); end
    if (err_field !== 3'd0) begin errors++; $display("FAIL err_field_hold got %0d need 0", err_field); end
  endtask

  task automatic test_start_while_busy();
    logic [47:0] d;
    d = 48'h25_06_15_12_30_45;
    run_seq(d, 1'b1);
    exp_bins = model_bins(d);
    checks += 4;
    if (r_ndone !== 1)       begin errors++; $display("FAIL busy_done_count got %0d need 1", r_ndone); end
    if (r_lat !== 7)         begin errors++; $display("FAIL busy_latency got %0d need 7", r_lat); end
    if (r_err !== 1'b0)      begin errors++; $display("FAIL busy_err got %b need 0", r_err); end
    if (r_bins !== exp_bins) begin errors++; $display("FAIL busy_bins got %h need %h", r_bins, exp_bins); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] d;
    int          de[$];
    d = rand_valid();
    @(negedge clk);
    bcd_in = d;
    start  = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) de.push_back(e);
    end
    start = 1'b0;
    exp_bins = model_bins(d);
    checks += 2;
    if (de.size() !== 4) begin errors++; $display("FAIL b2b_done_count got %0d need 4", de.size()); end
    if (dut_bins() !== exp_bins) begin errors++; $display("FAIL b2b_bins got %h need %h", dut_bins(), exp_bins); end
    foreach (de[i]) begin
      checks++;
      if (de[i] !== 6 + 8 * i) begin errors++; $display("FAIL b2b_done%0d_edge got %0d need %0d", i, de[i], 6 + 8 * i); end
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    logic [32:0] want;
    nd = 0;
    @(negedge clk);
    while (busy !== 1'b0) @(negedge clk);
    bcd_in = 48'h99_13_31_23_59_58;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 5;
    if (nd !== 0)           begin errors++; $display("FAIL rmid_done_seen got %0d need 0", nd); end
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_busy_done got %b%b need 00", busy, done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL rmid_err got %b need 0", err); end
    if (err_field !== 3'd7) begin errors++; $display("FAIL rmid_err_field got %0d need 7", err_field); end
    if (dut_bins() !== '0)  begin errors++; $display("FAIL rmid_bins got %h need 0", dut_bins()); end
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(48'h00_01_01_00_00_00, 1'b0);
    want = {7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0};
    exp_bins = want;
    checks += 3;
    if (r_lat !== 7)     begin errors++; $display("FAIL rmid_restart_latency got %0d need 7", r_lat); end
    if (r_err !== 1'b0)  begin errors++; $display("FAIL rmid_restart_err got %b need 0", r_err); end
    if (r_bins !== want) begin errors++; $display("FAIL rmid_restart_bins got %h need %h", r_bins, want); end
  endtask

  task automatic test_random();
    logic [47:0] d;
    int f, k;
    for (int it = 0; it < 40; it++) begin
      d = rand_valid();
      if ($urandom_range(1) == 1) begin
        k = $urandom_range(5);
        d[k*8 +: 8] = 8'($urandom);
      end
      f = model_fail(d);
      if (f == 7) exp_bins = model_bins(d);
      run_seq(d, 1'b0);
      checks += 5;
      if (r_ndone !== 1)                     begin errors++; $display("FAIL rnd%0d_done_count got %0d need 1", it, r_ndone); end
      if (r_lat !== ((f == 7) ? 7 : f + 2))  begin errors++; $display("FAIL rnd%0d_latency got %0d need %0d d=%h", it, r_lat, (f == 7) ? 7 : f + 2, d); end
      if (r_err !== (f != 7))                begin errors++; $display("FAIL rnd%0d_err got %b need %b d=%h", it, r_err, f != 7, d); end
      if (r_ef !== 3'(f))                    begin errors++; $display("FAIL rnd%0d_err_field got %0d need %0d d=%h", it, r_ef, f, d); end
      if (r_bins !== exp_bins)               begin errors++; $display("FAIL rnd%0d_bins got %h need %h d=%h", it, r_bins, exp_bins, d); end
    end
  endtask

  initial begin
    test_reset();
    test_valid_max();
    test_bad_digit();
    test_range_errors();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
